// File: rtl/hw_regs_reader.sv
// hw_regs_reader: cache-line read-back of the byte-wide HW_REGS bank through a 2-stage valid/ready pipeline.
// Optional request tagging (TAG_IN/TAG_OUT) is compiled in when HWREGS_RD_TAG_EN is defined.
module hw_regs_reader #(
    parameter int                      PORT_ADDR_SIZE     = 19,
    parameter int                      PORT_CACHE_BITS    = 128,
    parameter int                      HW_REGS_SIZE       = 14,
    parameter logic [PORT_ADDR_SIZE:0] BASE_WRITE_ADDRESS = '0,
    parameter int                      TAG_BITS           = 4
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                RD_REQ,
    output logic                                REQ_READY,
    input  logic [PORT_ADDR_SIZE-1:0]           ADDR_IN,
    input  logic [8*(2**HW_REGS_SIZE)-1:0]      HW_REGS,
    input  logic                                OUT_READY,
    output logic                                RD_VALID,
    output logic [PORT_CACHE_BITS-1:0]          DATA_OUT,
    output logic                                RD_HIT,
`ifdef HWREGS_RD_TAG_EN
    input  logic [TAG_BITS-1:0]                 TAG_IN,
    output logic [TAG_BITS-1:0]                 TAG_OUT,
`endif
    output logic [15:0]                         MISS_COUNT
);

    localparam int BYTES     = PORT_CACHE_BITS / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int LINE_BITS = HW_REGS_SIZE - LANE_BITS;

    logic                        ready_en_reg;
    logic                        s1_valid_reg;
    logic [LINE_BITS-1:0]        s1_line_reg;
    logic                        s1_hit_reg;
    logic                        valid_reg;
    logic [PORT_CACHE_BITS-1:0]  data_reg;
    logic                        hit_reg;
    logic [15:0]                 miss_count_reg;

    logic                        s2_stall;
    logic                        accept;
    logic                        addr_hit;
    logic [PORT_CACHE_BITS-1:0]  gather_line;
    logic                        unused_lane;

    // Lane bits only select a byte within the line; the request is always line aligned.
    assign unused_lane = ^ADDR_IN[LANE_BITS-1:0];

    assign addr_hit  = (ADDR_IN[PORT_ADDR_SIZE-1:HW_REGS_SIZE] ==
                        BASE_WRITE_ADDRESS[PORT_ADDR_SIZE-1:HW_REGS_SIZE]);
    assign s2_stall  = valid_reg && !OUT_READY;
    assign REQ_READY = ready_en_reg && !(s1_valid_reg && s2_stall);
    assign accept    = RD_REQ && REQ_READY;

    // Byte i of the line comes from bank address {line, i}: no lane swap.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [HW_REGS_SIZE+2:0] bit_idx;
            assign bit_idx = {s1_line_reg, LANE_BITS'(gi), 3'b000};
            assign gather_line[gi*8 +: 8] = HW_REGS[bit_idx +: 8];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ready_en_reg   <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_line_reg    <= '0;
            s1_hit_reg     <= 1'b0;
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            hit_reg        <= 1'b0;
            miss_count_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (!s2_stall) begin
                valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    data_reg <= s1_hit_reg ? gather_line : '0;
                    hit_reg  <= s1_hit_reg;
                end
            end
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_line_reg  <= ADDR_IN[HW_REGS_SIZE-1:LANE_BITS];
                s1_hit_reg   <= addr_hit;
                if (!addr_hit && miss_count_reg != 16'hFFFF) begin
                    miss_count_reg <= miss_count_reg + 16'd1;
                end
            end else if (!s2_stall) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

`ifdef HWREGS_RD_TAG_EN
    logic [TAG_BITS-1:0] s1_tag_reg;
    logic [TAG_BITS-1:0] tag_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_tag_reg <= '0;
            tag_reg    <= '0;
        end else begin
            if (!s2_stall && s1_valid_reg) begin
                tag_reg <= s1_tag_reg;
            end
            if (accept) begin
                s1_tag_reg <= TAG_IN;
            end
        end
    end

    assign TAG_OUT = tag_reg;
`endif

    assign RD_VALID   = valid_reg;
    assign DATA_OUT   = data_reg;
    assign RD_HIT     = hit_reg;
    assign MISS_COUNT = miss_count_reg;

endmodule

// File: tb/tb_hw_regs_reader.sv
// Self-checking bench for hw_regs_reader: directed scenarios plus randomized traffic against a queue-based model.
// Tag checks are compiled in when HWREGS_RD_TAG_EN is defined.
module tb_hw_regs_reader;

    localparam int NBYTES = 16384;

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic                  RD_REQ;
    logic                  REQ_READY;
    logic [18:0]           ADDR_IN;
    logic [8*NBYTES-1:0]   HW_REGS;
    logic                  OUT_READY;
    logic                  RD_VALID;
    logic [127:0]          DATA_OUT;
    logic                  RD_HIT;
    logic [15:0]           MISS_COUNT;
`ifdef HWREGS_RD_TAG_EN
    logic [3:0]            TAG_IN;
    logic [3:0]            TAG_OUT;
`endif

    always #5 CLK = ~CLK;

    hw_regs_reader dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RD_REQ     (RD_REQ),
        .REQ_READY  (REQ_READY),
        .ADDR_IN    (ADDR_IN),
        .HW_REGS    (HW_REGS),
        .OUT_READY  (OUT_READY),
        .RD_VALID   (RD_VALID),
        .DATA_OUT   (DATA_OUT),
        .RD_HIT     (RD_HIT),
`ifdef HWREGS_RD_TAG_EN
        .TAG_IN     (TAG_IN),
        .TAG_OUT    (TAG_OUT),
`endif
        .MISS_COUNT (MISS_COUNT)
    );

    typedef struct {
        logic [127:0] data;
        logic         hit;
        logic [3:0]   tag;
        int           acc;
    } item_t;

    item_t       q[$];
    logic [7:0]  mem [NBYTES];
    int          cyc;
    int          compared;
    int          mismatched;
    logic [15:0] exp_miss;

    logic         obs_ready, obs_valid, obs_hit;
    logic [127:0] obs_data;
    logic [15:0]  obs_miss;
    logic [3:0]   obs_tag;
    logic         exp_ready, exp_valid, exp_hit;
    logic [127:0] exp_data;
    logic [3:0]   exp_tag;
    logic [15:0]  exp_miss_s;

    function automatic logic in_window(input logic [18:0] a);
        return (a >> 14) == 19'd0;
    endfunction

    function automatic logic [127:0] model_line(input logic [18:0] a);
        logic [127:0] r;
        int base;
        r = '0;
        if (!in_window(a)) return r;
        base = (int'(a) % NBYTES) / 16 * 16;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = mem[base + i];
        return r;
    endfunction

    function automatic logic [18:0] rand_hit_addr();
        return {5'd0, 14'($urandom)};
    endfunction

    function automatic logic [18:0] rand_miss_addr();
        return {5'($urandom_range(1, 31)), 14'($urandom)};
    endfunction

    task automatic set_byte(input int a, input logic [7:0] v);
        mem[a] = v;
        HW_REGS[a*8 +: 8] = v;
    endtask

    // Drives one cycle, snapshots DUT outputs and model expectations, then advances the model past the edge.
    task automatic drive_cycle(input logic req, input logic [18:0] addr, input logic ordy, input logic [3:0] tag);
        item_t it;
        logic acc, con;
        RD_REQ = req;
        ADDR_IN = addr;
        OUT_READY = ordy;
`ifdef HWREGS_RD_TAG_EN
        TAG_IN = tag;
`endif
        #1;
        obs_ready = REQ_READY;
        obs_valid = RD_VALID;
        obs_hit   = RD_HIT;
        obs_data  = DATA_OUT;
        obs_miss  = MISS_COUNT;
`ifdef HWREGS_RD_TAG_EN
        obs_tag   = TAG_OUT;
`else
        obs_tag   = '0;
`endif
        exp_ready  = (q.size() < 2) || ordy;
        exp_valid  = (q.size() > 0) && (q[0].acc < cyc);
        exp_data   = exp_valid ? q[0].data : '0;
        exp_hit    = exp_valid ? q[0].hit : 1'b0;
        exp_tag    = exp_valid ? q[0].tag : 4'd0;
        exp_miss_s = exp_miss;
        acc = req && exp_ready;
        con = exp_valid && ordy;
        @(posedge CLK);
        cyc++;
        #1;
        if (con) void'(q.pop_front());
        if (acc) begin
            it.data = model_line(addr);
            it.hit  = in_window(addr);
            it.tag  = tag;
            it.acc  = cyc;
            q.push_back(it);
            if (!it.hit && exp_miss != 16'hFFFF) exp_miss++;
        end
    endtask

    task automatic hold_reset(input int n);
        RESET = 1'b1;
        RD_REQ = 1'b0;
        OUT_READY = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic release_reset();
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        q.delete();
        exp_miss = '0;
    endtask

    task automatic test_reset();
        hold_reset(2);
        compared++; if (REQ_READY !== 1'b0) begin mismatched++; $display("FAIL reset_req_ready: got %b want 0", REQ_READY); end
        compared++; if (RD_VALID !== 1'b0) begin mismatched++; $display("FAIL reset_rd_valid: got %b want 0", RD_VALID); end
        compared++; if (DATA_OUT !== 128'd0) begin mismatched++; $display("FAIL reset_data: got %h want 0", DATA_OUT); end
        compared++; if (RD_HIT !== 1'b0) begin mismatched++; $display("FAIL reset_rd_hit: got %b want 0", RD_HIT); end
        compared++; if (MISS_COUNT !== 16'd0) begin mismatched++; $display("FAIL reset_miss_count: got %h want 0", MISS_COUNT); end
        release_reset();
        compared++; if (REQ_READY !== 1'b1) begin mismatched++; $display("FAIL post_reset_ready: got %b want 1", REQ_READY); end
        $display("reset: ready=%b valid=%b miss=%0d", REQ_READY, RD_VALID, MISS_COUNT);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) set_byte(i, 8'(i));
        drive_cycle(1'b1, 19'h00000, 1'b1, 4'hA);
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
        compared++; if (obs_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %b want 0", obs_valid); end
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
        compared++; if (obs_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid: got %b want 1", obs_valid); end
        compared++; if (obs_hit !== 1'b1) begin mismatched++; $display("FAIL basic_hit: got %b want 1", obs_hit); end
        compared++; if (obs_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            mismatched++; $display("FAIL basic_data: got %h want 0f0e0d0c0b0a09080706050403020100", obs_data); end
`ifdef HWREGS_RD_TAG_EN
        compared++; if (obs_tag !== 4'hA) begin mismatched++; $display("FAIL basic_tag: got %h want a", obs_tag); end
`endif
        $display("txn basic addr=00000 hit=%b data=%h", obs_hit, obs_data);
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
    endtask

    task automatic test_unaligned();
        drive_cycle(1'b1, 19'h00013, 1'b1, 4'h3);
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
        compared++; if (obs_valid !== 1'b1) begin mismatched++; $display("FAIL unaligned_valid: got %b want 1", obs_valid); end
        compared++; if (obs_data !== model_line(19'h00010)) begin
            mismatched++; $display("FAIL unaligned_data: got %h want %h", obs_data, model_line(19'h00010)); end
        $display("txn unaligned addr=00013 hit=%b data=%h", obs_hit, obs_data);
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
    endtask

    task automatic test_miss();
        drive_cycle(1'b1, 19'h04000, 1'b1, 4'h5);
        compared++; if (obs_miss !== 16'd0) begin mismatched++; $display("FAIL miss_count_before: got %0d want 0", obs_miss); end
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
        compared++; if (obs_valid !== 1'b1) begin mismatched++; $display("FAIL miss_valid: got %b want 1", obs_valid); end
        compared++; if (obs_hit !== 1'b0) begin mismatched++; $display("FAIL miss_hit: got %b want 0", obs_hit); end
        compared++; if (obs_data !== 128'd0) begin mismatched++; $display("FAIL miss_data: got %h want 0", obs_data); end
        compared++; if (obs_miss !== 16'd1) begin mismatched++; $display("FAIL miss_count_after: got %0d want 1", obs_miss); end
        $display("txn miss addr=04000 hit=%b data=%h miss=%0d", obs_hit, obs_data, obs_miss);
        drive_cycle(1'b0, 19'h00000, 1'b1, 4'h0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            drive_cycle(k < 4, rand_hit_addr(), 1'b1, 4'(k));
            compared++; if (obs_valid !== (k >= 2 && k <= 5)) begin
                mismatched++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, obs_valid, (k >= 2 && k <= 5)); end
            if (k < 4) begin
                compared++; if (obs_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, obs_ready); end
            end
            if (exp_valid) begin
                compared++; if (obs_data !== exp_data || obs_hit !== exp_hit) begin
                    mismatched++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", k, obs_data, obs_hit, exp_data, exp_hit); end
                $display("txn b2b[%0d] hit=%b data=%h", k, obs_hit, obs_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [18:0]  addrs [3];
        logic [127:0] held;
        int idx;
        int results;
        idx = 0;
        results = 0;
        held = '0;
        for (int i = 0; i < 3; i++) addrs[i] = rand_hit_addr();
        for (int k = 0; k < 5; k++) begin
            drive_cycle(idx < 3, addrs[idx < 3 ? idx : 2], 1'b0, 4'(idx));
            compared++; if (obs_ready !== exp_ready || (k >= 2 && obs_ready !== 1'b0)) begin
                mismatched++; $display("FAIL bp_ready[%0d]: got %b want %b", k, obs_ready, exp_ready && k < 2); end
            if (k == 2) held = obs_data;
            if (k > 2) begin
                compared++; if (obs_data !== held || obs_valid !== 1'b1) begin
                    mismatched++; $display("FAIL bp_stable[%0d]: got %h/%b want %h/1", k, obs_data, obs_valid, held); end
            end
            if (exp_ready && idx < 3) idx++;
        end
        for (int k = 0; k < 6; k++) begin
            drive_cycle(idx < 3, addrs[idx < 3 ? idx : 2], 1'b1, 4'(idx));
            if (exp_ready && idx < 3) idx++;
            compared++; if (obs_valid !== exp_valid) begin
                mismatched++; $display("FAIL bp_drain_valid[%0d]: got %b want %b", k, obs_valid, exp_valid); end
            if (exp_valid) begin
                results++;
                compared++; if (obs_data !== exp_data) begin
                    mismatched++; $display("FAIL bp_drain_data[%0d]: got %h want %h", k, obs_data, exp_data); end
                $display("txn bp[%0d] hit=%b data=%h", results, obs_hit, obs_data);
            end
        end
        compared++; if (results !== 3) begin mismatched++; $display("FAIL bp_result_count: got %0d want 3", results); end
    endtask

    task automatic test_random();
        logic [18:0] a;
        logic        req;
        for (int k = 0; k < 400; k++) begin
            a = ($urandom_range(0, 3) == 0) ? rand_miss_addr() : rand_hit_addr();
            req = ($urandom_range(0, 3) != 0);
            drive_cycle(req, a, $urandom_range(0, 2) != 0, 4'($urandom));
            compared++; if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_miss !== exp_miss_s) begin
                mismatched++; $display("FAIL rand_ctrl[%0d]: got rdy=%b vld=%b miss=%0d want rdy=%b vld=%b miss=%0d",
                    k, obs_ready, obs_valid, obs_miss, exp_ready, exp_valid, exp_miss_s); end
            if (exp_valid) begin
                compared++; if (obs_data !== exp_data || obs_hit !== exp_hit) begin
                    mismatched++; $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", k, obs_data, obs_hit, exp_data, exp_hit); end
`ifdef HWREGS_RD_TAG_EN
                compared++; if (obs_tag !== exp_tag) begin
                    mismatched++; $display("FAIL rand_tag[%0d]: got %h want %h", k, obs_tag, exp_tag); end
`endif
            end
        end
        repeat (3) drive_cycle(1'b0, 19'h0, 1'b1, 4'h0);
        $display("txn random: 400 cycles, model miss count=%0d", exp_miss);
    endtask

    task automatic test_saturation();
        int extra;
        extra = 0;
        for (int i = 0; i < 70000 && extra < 4; i++) begin
            drive_cycle(1'b1, rand_miss_addr(), 1'b1, 4'h0);
            if (exp_miss_s >= 16'hFFFC) begin
                compared++; if (obs_miss !== exp_miss_s) begin
                    mismatched++; $display("FAIL sat_count: got %h want %h", obs_miss, exp_miss_s); end
            end
            if (exp_miss == 16'hFFFF) extra++;
        end
        repeat (3) drive_cycle(1'b0, 19'h0, 1'b1, 4'h0);
        compared++; if (obs_miss !== 16'hFFFF) begin mismatched++; $display("FAIL sat_final: got %h want ffff", obs_miss); end
        $display("txn saturation miss=%h", obs_miss);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, rand_miss_addr(), 1'b0, 4'h1);
        drive_cycle(1'b1, rand_hit_addr(), 1'b0, 4'h2);
        hold_reset(1);
        release_reset();
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b0, 19'h0, 1'b1, 4'h0);
            compared++; if (obs_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid[%0d]: got %b want 0", k, obs_valid); end
            compared++; if (obs_miss !== 16'd0) begin mismatched++; $display("FAIL rstmid_miss[%0d]: got %0d want 0", k, obs_miss); end
        end
        $display("txn reset_mid valid=%b miss=%0d", obs_valid, obs_miss);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        compared = 0;
        mismatched = 0;
        cyc = 0;
        exp_miss = '0;
        RESET = 1'b1;
        RD_REQ = 1'b0;
        ADDR_IN = '0;
        OUT_READY = 1'b1;
        HW_REGS = '0;
`ifdef HWREGS_RD_TAG_EN
        TAG_IN = '0;
`endif
        for (int i = 0; i < NBYTES; i++) set_byte(i, 8'($urandom));
        @(posedge CLK);
        #1;
        test_reset();
        test_basic();
        test_unaligned();
        test_miss();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
